data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 219 +++++++++++++++++++++
 tb/tb_data_cache.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Set-associative write-through, no-write-allocate data cache with PLRU replacement.
// Latency: a load hit returns data in the same cycle. A load miss fills BLOCK_WORDS words, then hits on retry. A store completes on its mem_ack.
// Backpressure: cpu_ready stays low while the CPU must stall. Each mem request is held stable until mem_ack.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   cpu_req/we/be/addr/wdata, cpu_rdata, cpu_ready : CPU access port
//   flush              : one-cycle pulse that invalidates every line
//   mem_req/we/addr/wdata/be, mem_ack, mem_rdata   : backing-memory port, one word per ack
//   hit_count, miss_count                          : saturating lookup statistics
module data_cache #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_be,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  flush,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int OFF_BITS = $clog2(BLOCK_WORDS);
  localparam int WO_W     = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_W    = ADDR_WIDTH - 2 - OFF_BITS - IDX_BITS;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_WIDTH-1:0] WMASK     = ADDR_WIDTH'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ADDR_WIDTH'(4 * BLOCK_WORDS - 1);
  localparam logic [WO_W-1:0]       LAST_WORD = WO_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_FLUSH} state_t;

  state_t                r_state;
  logic [WAYS-1:0]       r_valid [SETS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS][BLOCK_WORDS];
  // bit0: root (1 = victim in upper half / way1 for 2 ways); bit1/bit2: lower/upper pair.
  logic [2:0]            r_plru  [SETS];
  logic                  r_flush_pend;
  logic [WO_W-1:0]       r_cnt;
  logic [WAY_W-1:0]      r_way;       // fill victim, or hit way of a pending store
  logic                  r_wr_hit;
  logic [31:0]           r_hit_cnt, r_miss_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_be;

  logic [IDX_BITS-1:0]   w_idx, w_m_idx;
  logic [TAG_W-1:0]      w_tag, w_m_tag;
  logic [WO_W-1:0]       w_word, w_m_word;
  logic                  w_hit, w_ld_hit, w_fill_last;
  logic [WAY_W-1:0]      w_hit_way, w_victim;
  logic [DATA_WIDTH-1:0] w_hit_word;

  function automatic logic [1:0] f_victim(input logic [2:0] p);
    if (WAYS == 4)      return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    else if (WAYS == 2) return {1'b0, p[0]};
    else                return 2'b00;
  endfunction

  // Point the tree away from the way just used.
  function automatic logic [2:0] f_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] n;
    n = p;
    if (WAYS == 4) begin
      n[0] = ~w[1];
      if (!w[1]) n[1] = ~w[0];
      else       n[2] = ~w[0];
    end else if (WAYS == 2) begin
      n[0] = ~w[0];
    end
    return n;
  endfunction

  // CPU-side fields feed the lookup; fields of the held mem address steer fills and store merges.
  assign w_idx    = IDX_BITS'(cpu_addr >> (2 + OFF_BITS));
  assign w_tag    = TAG_W'(cpu_addr >> (2 + OFF_BITS + IDX_BITS));
  assign w_word   = WO_W'((cpu_addr >> 2) & WMASK);
  assign w_m_idx  = IDX_BITS'(r_mem_addr >> (2 + OFF_BITS));
  assign w_m_tag  = TAG_W'(r_mem_addr >> (2 + OFF_BITS + IDX_BITS));
  assign w_m_word = WO_W'((r_mem_addr >> 2) & WMASK);

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    w_hit_word = r_data[w_idx][w_hit_way][w_word];
    // Lowest-numbered invalid way wins over the PLRU choice.
    w_victim = WAY_W'(f_victim(r_plru[w_idx]));
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
    end
  end

  assign w_ld_hit    = (r_state == S_IDLE) && cpu_req && !cpu_we && !flush && w_hit;
  assign w_fill_last = (r_state == S_FILL) && mem_ack && (r_cnt == LAST_WORD);

  assign cpu_ready  = !rst && (w_ld_hit || (r_state == S_WRITE && mem_ack));
  assign cpu_rdata  = (!rst && w_ld_hit) ? w_hit_word : '0;
  assign mem_req    = !rst && (r_state == S_FILL || r_state == S_WRITE);
  assign mem_we     = !rst && (r_state == S_WRITE);
  assign mem_addr   = rst ? '0 : r_mem_addr;
  assign mem_wdata  = rst ? '0 : r_mem_wdata;
  assign mem_be     = rst ? '0 : r_mem_be;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_flush_pend <= 1'b0;
      r_cnt        <= '0;
      r_way        <= '0;
      r_wr_hit     <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state <= S_FLUSH;
          end else if (cpu_req) begin
            if (w_hit) begin
              if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
              if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (cpu_we) begin
              r_state     <= S_WRITE;
              r_mem_addr  <= cpu_addr & ~ADDR_WIDTH'(3);
              r_mem_wdata <= cpu_wdata;
              r_mem_be    <= cpu_be;
              r_way       <= w_hit_way;
              r_wr_hit    <= w_hit;
            end else if (w_hit) begin
              r_plru[w_idx] <= f_touch(r_plru[w_idx], 2'(w_hit_way));
            end else begin
              r_state    <= S_FILL;
              r_mem_addr <= cpu_addr & ~BLK_MASK;
              r_mem_be   <= 4'hF;
              r_cnt      <= '0;
              r_way      <= w_victim;
            end
          end
        end
        S_FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_ack) begin
            if (r_cnt == LAST_WORD) begin
              r_valid[w_m_idx][r_way] <= 1'b1;
              r_plru[w_m_idx]         <= f_touch(r_plru[w_m_idx], 2'(r_way));
              r_cnt                   <= '0;
              r_state                 <= (r_flush_pend || flush) ? S_FLUSH : S_IDLE;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
            end
          end
        end
        S_WRITE: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_ack) begin
            if (r_wr_hit) r_plru[w_m_idx] <= f_touch(r_plru[w_m_idx], 2'(r_way));
            r_state <= (r_flush_pend || flush) ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_plru[s]  <= '0;
          end
          r_flush_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_FILL && mem_ack) r_data[w_m_idx][r_way][r_cnt] <= mem_rdata;
      if (w_fill_last) r_tag[w_m_idx][r_way] <= w_m_tag;
      if (r_state == S_WRITE && mem_ack && r_wr_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (r_mem_be[b]) r_data[w_m_idx][r_way][w_m_word][8*b +: 8] <= r_mem_wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a reference model predicts CPU responses and memory traffic.
// Latency: stimulus waits a bounded number of cycles for each cpu_ready.
// Backpressure: the memory model acks after a random 0-2 cycle delay.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst, cpu_req, cpu_we, flush;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;
  logic [3:0]  mem_be;
  logic        mem_auto, auto_ack, man_ack;

  always #5 clk = ~clk;

  assign mem_ack = mem_auto ? auto_ack : man_ack;

  data_cache dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {bit we; logic [31:0] data;} cpu_exp_t;
  typedef struct {bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] data;} mem_op_t;

  cpu_exp_t    exp_cpu[$];
  mem_op_t     exp_mem[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] bmem [4096];   // backing memory, changed only by DUT writes
  logic [31:0] rmem [4096];   // reference memory, changed by the model
  bit          mv [16][2];
  int unsigned mt [16][2];
  int unsigned ms [16][2];    // last-use timestamps: smaller = less recently used
  int unsigned tick, m_hit, m_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_inval();
    for (int s = 0; s < 16; s++) for (int w = 0; w < 2; w++) begin mv[s][w] = 0; ms[s][w] = 0; end
  endtask

  task automatic model_reset();
    model_inval();
    m_hit = 0; m_miss = 0; tick = 0;
    exp_cpu.delete(); exp_mem.delete();
  endtask

  task automatic model_fill(input logic [31:0] addr, input int s, input int unsigned tg, output int way);
    mem_op_t op;
    for (int k = 0; k < 4; k++) begin
      op.we = 0; op.addr = (addr & ~32'hF) + 32'(4 * k); op.be = 4'hF; op.data = 0;
      exp_mem.push_back(op);
    end
    if (!mv[s][0])      way = 0;
    else if (!mv[s][1]) way = 1;
    else                way = (ms[s][0] <= ms[s][1]) ? 0 : 1;
    mv[s][way] = 1; mt[s][way] = tg; ms[s][way] = ++tick;
  endtask

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input bit ff, input bit fm);
    int s, hw, wi;
    int unsigned tg;
    mem_op_t op;
    cpu_exp_t ce;
    s = int'(addr[7:4]); tg = addr >> 8; wi = int'(addr[13:2]); hw = -1;
    if (ff) model_inval();
    for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == tg) hw = w;
    if (!we) begin
      if (hw < 0) begin
        m_miss++; model_fill(addr, s, tg, hw);
        if (fm) begin model_inval(); m_miss++; model_fill(addr, s, tg, hw); end
      end
      m_hit++; ms[s][hw] = ++tick;
      ce.we = 0; ce.data = rmem[wi];
    end else begin
      if (hw >= 0) begin m_hit++; ms[s][hw] = ++tick; end
      else m_miss++;
      op.we = 1; op.addr = addr & ~32'h3; op.be = be; op.data = wd;
      exp_mem.push_back(op);
      for (int b = 0; b < 4; b++) if (be[b]) rmem[wi][8*b +: 8] = wd[8*b +: 8];
      ce.we = 1; ce.data = 0;
    end
    exp_cpu.push_back(ce);
  endtask

  // Issue one access and hold it until cpu_ready; lat counts cycles waited.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input bit ff, input bit fm,
                           output logic [31:0] rd, output int lat);
    bit got;
    model_access(we, addr, be, wd, ff, fm);
    cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd; cpu_req = 1; flush = ff;
    if (ff) begin @(posedge clk); #1 flush = 0; end
    got = 0; rd = 0; lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cpu_ready) begin got = 1; rd = cpu_rdata; lat = i; break; end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL access_timeout: addr %h got no cpu_ready, expected one within 400 cycles", addr);
    end
    @(posedge clk); #1 cpu_req = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    model_reset();
  endtask

  // Response monitor.
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && cpu_req && cpu_ready) begin
        if (exp_cpu.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_ready: got cpu_ready at addr %h, expected none", cpu_addr);
        end else begin
          e = exp_cpu.pop_front();
          chk("resp_kind", 32'(cpu_we), 32'(e.we));
          if (!e.we) chk("cpu_rdata", cpu_rdata, e.data);
        end
      end
    end
  end

  // Backing memory: checks each transaction against the model, then acks.
  initial begin
    int wait_cnt;
    mem_op_t e;
    auto_ack = 0; mem_rdata = 0; wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (auto_ack) auto_ack = 0;
      else if (mem_auto && mem_req && !rst) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          if (exp_mem.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_mem: got mem_req we=%0d addr %h, expected none", mem_we, mem_addr);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) begin
              chk("mem_be", 32'(mem_be), 32'(e.be));
              chk("mem_wdata", mem_wdata, e.data);
            end
          end
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) bmem[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end else mem_rdata = bmem[mem_addr[13:2]];
          auto_ack = 1;
          wait_cnt = $urandom_range(0, 2);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, found, gap;
    bit we, ff;
    logic [31:0] addr, wd;
    logic [3:0] be;
    for (int i = 0; i < 4096; i++) begin bmem[i] = $urandom; rmem[i] = bmem[i]; end
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0; flush = 0;
    mem_auto = 1; man_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);

    // Cold load fills a line; a neighbouring word then hits immediately.
    bmem['h40] = 32'hCAFE0100; rmem['h40] = 32'hCAFE0100;
    bmem['h41] = 32'hCAFE0104; rmem['h41] = 32'hCAFE0104;
    do_access(0, 32'h100, 4'h0, 0, 0, 0, rd, lat);
    chk("cold_data", rd, 32'hCAFE0100);
    chk("cold_misses", miss_count, 1);
    do_access(0, 32'h104, 4'h0, 0, 0, 0, rd, lat);
    chk("hit_data", rd, 32'hCAFE0104);
    chk("hit_latency", 32'(lat), 0);
    chk("hit_count2", hit_count, 2);

    // LRU: 0x300 evicts 0x200, not the more recently used 0x100.
    do_reset();
    do_access(0, 32'h100, 4'h0, 0, 0, 0, rd, lat);
    do_access(0, 32'h200, 4'h0, 0, 0, 0, rd, lat);
    do_access(0, 32'h100, 4'h0, 0, 0, 0, rd, lat);
    do_access(0, 32'h300, 4'h0, 0, 0, 0, rd, lat);
    do_access(0, 32'h100, 4'h0, 0, 0, 0, rd, lat);
    chk("lru_keep_lat", 32'(lat), 0);
    do_access(0, 32'h200, 4'h0, 0, 0, 0, rd, lat);
    chk("lru_misses", miss_count, 4);
    chk("lru_hits", hit_count, 6);

    // Store hit merges enabled bytes into the cached word.
    do_reset();
    bmem['h40] = 32'h11223344; rmem['h40] = 32'h11223344;
    do_access(0, 32'h100, 4'h0, 0, 0, 0, rd, lat);
    do_access(1, 32'h100, 4'b0011, 32'hAAAABBBB, 0, 0, rd, lat);
    do_access(0, 32'h100, 4'h0, 0, 0, 0, rd, lat);
    chk("merge_data", rd, 32'h1122BBBB);
    chk("merge_lat", 32'(lat), 0);

    // Store miss does not allocate.
    do_reset();
    do_access(1, 32'h400, 4'hF, 32'h12345678, 0, 0, rd, lat);
    do_access(0, 32'h400, 4'h0, 0, 0, 0, rd, lat);
    chk("nwa_data", rd, 32'h12345678);
    chk("nwa_misses", miss_count, 2);
    chk("nwa_hits", hit_count, 1);

    // Flush during a fill: fill completes, then the retried load misses again.
    do_reset();
    fork
      do_access(0, 32'h500, 4'h0, 0, 0, 1, rd, lat);
      begin
        int seen;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (mem_req && mem_addr == 32'h504) begin seen = 1; break; end
        end
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        chk("flush_word1_seen", 32'(seen), 1);
      end
    join
    chk("flush_misses", miss_count, 2);
    chk("flush_hits", hit_count, 1);

    // Reset on the third fill word; late acks are ignored.
    do_reset();
    mem_auto = 0; man_ack = 0;
    cpu_we = 0; cpu_addr = 32'h100; cpu_req = 1;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (man_ack) man_ack = 0;
      else if (mem_req) begin
        if (mem_addr == 32'h108) begin found = 1; break; end
        man_ack = 1;
      end
    end
    chk("rst_fill_word2_seen", 32'(found), 1);
    rst = 1; man_ack = 1; cpu_req = 0;
    @(negedge clk);
    chk("rst_fill_mem_req", 32'(mem_req), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_mem_req", 32'(mem_req), 0);
    chk("post_rst_misses", miss_count, 0);
    chk("post_rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1 man_ack = 0; mem_auto = 1;
    model_reset();
    do_access(0, 32'h100, 4'h0, 0, 0, 0, rd, lat);
    chk("post_rst_load_misses", miss_count, 1);

    // Randomized traffic with idle gaps and occasional flushes.
    for (int n = 0; n < 300; n++) begin
      we = (($urandom % 3) == 0);
      addr = 32'($urandom_range(0, 1023)) << 2;
      be = 4'($urandom_range(1, 15));
      wd = $urandom;
      ff = (($urandom % 25) == 0);
      do_access(we, addr, be, wd, ff, 0, rd, lat);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        cpu_addr = $urandom; cpu_we = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_hits", hit_count, 32'(m_hit));
    chk("final_misses", miss_count, 32'(m_miss));
    chk("cpu_queue_drained", 32'(exp_cpu.size()), 0);
    chk("mem_queue_drained", 32'(exp_mem.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
